// File: rtl/mac_pkg.sv
// Shared types and helpers for the N-channel MAC engine: FSM state encoding,
// default saturation rails and the generic saturating resize.
package mac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_SERIAL} state_t;

  localparam int ACC_W_DEF = 20;
  localparam int OUT_W_DEF = 8;
  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W_DEF - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_W_DEF - 1));
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OUT_W_DEF - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OUT_W_DEF - 1));

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered full-width product, then a saturating accumulate.
module mac_lane
  import mac_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod_q;
  logic                   pv;
  logic signed [63:0]     sum;

  assign sum = {{(64-ACC_W){acc[ACC_W-1]}}, acc}
             + {{(64-2*DW){prod_q[2*DW-1]}}, prod_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      pv     <= 1'b0;
      acc    <= '0;
    end else begin
      pv <= en;
      if (en) prod_q <= a * b;
      if (clr)     acc <= '0;
      else if (pv) acc <= ACC_W'(sat_resize(sum, ACC_W));
    end
  end

endmodule

// File: rtl/mac_nch_engine.sv
// N-lane MAC engine: accumulate cfg_len operand beats per lane, then shift,
// optional ReLU and saturate each lane onto a serial valid/ready stream.
module mac_nch_engine
  import mac_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8,
  parameter int LEN_W = 8,
  localparam int SH_W = $clog2(ACC_W),
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [SH_W-1:0]    cfg_shift,
  input  logic               relu_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_CH*DW-1:0] in_a,
  input  logic [N_CH*DW-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_last,
  output logic               busy
);

  state_t                        state;
  logic [LEN_W-1:0]              len_q, cnt;
  logic [SH_W-1:0]               shift_q;
  logic                          relu_q;
  logic [N_CH-1:0][ACC_W-1:0]    acc;
  logic                          accept, clr;
  logic [CH_W-1:0]               sel_ch;
  logic signed [ACC_W-1:0]       sel_acc, shifted;
  logic signed [63:0]            r64;

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign clr      = start && (state == ST_IDLE);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (accept),
      .a   (in_a[i*DW +: DW]),
      .b   (in_b[i*DW +: DW]),
      .acc (acc[i])
    );
  end

  // Result for the lane about to be presented: lane 0 on entry, else the next one.
  always_comb begin
    sel_ch  = out_valid ? CH_W'(out_ch + 1'b1) : '0;
    sel_acc = $signed(acc[sel_ch]);
    shifted = sel_acc >>> shift_q;
    r64     = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
    if (relu_q && r64 < 0) r64 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          len_q   <= cfg_len;
          shift_q <= cfg_shift;
          relu_q  <= relu_en;
          cnt     <= '0;
          state   <= (cfg_len != '0) ? ST_ACCUM : ST_SERIAL;
        end
        ST_ACCUM: if (accept) begin
          cnt <= cnt + 1'b1;
          if (LEN_W'(cnt + 1'b1) == len_q) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_SERIAL;
        ST_SERIAL: begin
          // Accumulators settle on the SERIAL entry edge; first word loads one cycle later.
          if (!out_valid || (out_ready && !out_last)) begin
            out_valid <= 1'b1;
            out_ch    <= sel_ch;
            out_last  <= (sel_ch == CH_W'(N_CH - 1));
            out_data  <= OUT_W'(sat_resize(r64, OUT_W));
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_nch_engine.sv
// Directed bench for mac_nch_engine (N_CH=2, DW=8, ACC_W=20, OUT_W=8).
module tb_mac_nch_engine;

  logic        clk = 1'b0;
  logic        rst, start, relu_en, in_valid, out_ready;
  logic [7:0]  cfg_len;
  logic [4:0]  cfg_shift;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;

  int tests = 0;
  int fails = 0;
  logic [7:0] rd [0:1];
  logic       rc [0:1];
  logic       rl [0:1];

  always #5 clk = ~clk;

  mac_nch_engine #(.N_CH(2), .DW(8), .ACC_W(20), .OUT_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic [4:0] sh, input logic relu);
    start = 1'b1; cfg_len = len; cfg_shift = sh; relu_en = relu;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] a0, b0, a1, b1, input bit gaps);
    int  sent = 0;
    int  guard = 0;
    bit  go;
    in_a = {a1, a0};
    in_b = {b1, b0};
    while (sent < n && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      go = in_valid && in_ready;
      tick();
      if (go) sent++;
      guard++;
    end
    in_valid = 1'b0;
    tests++;
    if (sent != n) begin
      fails++;
      $display("FAIL feed_count got %0d beats want %0d", sent, n);
    end
  endtask

  task automatic collect();
    int g;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      g = 0;
      while (!out_valid && g < 20) begin tick(); g++; end
      tests++;
      if (!out_valid) begin
        fails++;
        $display("FAIL collect_timeout word %0d never valid", k);
      end
      rd[k] = out_data; rc[k] = out_ch[0]; rl[k] = out_last;
      tick();
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, out_data, out_ch, out_last, busy} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h ch=%b last=%b busy=%b want all 0",
               in_ready, out_valid, out_data, out_ch, out_last, busy);
    end
  endtask

  task automatic test_basic();
    start_job(8'd3, 5'd0, 1'b0);
    feed(3, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_lat0 vld=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1 vld=%b want 0", out_valid); end
    tick();
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_lat2 vld=%b want 1", out_valid); end
    collect();
    tests++;
    if (rd[0] !== 8'd18 || rc[0] !== 1'b0 || rl[0] !== 1'b0) begin
      fails++; $display("FAIL basic_ch0 data=%0d ch=%b last=%b want 18 0 0", rd[0], rc[0], rl[0]);
    end
    tests++;
    if (rd[1] !== 8'hC4 || rc[1] !== 1'b1 || rl[1] !== 1'b1) begin
      fails++; $display("FAIL basic_ch1 data=%h ch=%b last=%b want c4 1 1", rd[1], rc[1], rl[1]);
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_idle busy=%b vld=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_relu();
    start_job(8'd3, 5'd0, 1'b1);
    feed(3, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    collect();
    tests++;
    if (rd[0] !== 8'd18 || rd[1] !== 8'd0) begin
      fails++; $display("FAIL relu got %0d %0d want 18 0", rd[0], rd[1]);
    end
  endtask

  task automatic test_saturation();
    start_job(8'd255, 5'd12, 1'b0);
    feed(255, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
    tick();
    tests++;
    if (dut.acc[0] !== 20'h7FFFF || dut.acc[1] !== 20'h7FFFF) begin
      fails++; $display("FAIL sat_acc got %h %h want 7ffff 7ffff", dut.acc[0], dut.acc[1]);
    end
    collect();
    tests++;
    if (rd[0] !== 8'd127 || rd[1] !== 8'd127) begin
      fails++; $display("FAIL sat_shift12 got %0d %0d want 127 127", rd[0], rd[1]);
    end
    start_job(8'd255, 5'd0, 1'b0);
    feed(255, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
    collect();
    tests++;
    if (rd[0] !== 8'd127 || rd[1] !== 8'd127) begin
      fails++; $display("FAIL sat_shift0 got %0d %0d want 127 127", rd[0], rd[1]);
    end
  endtask

  // ch0 4*(7*-3)=-84 >>>2 = -21 (0xEB); ch1 4*100=400 >>>2 = 100
  task automatic test_back_to_back();
    logic [7:0] d;
    logic       c;
    int         g = 0;
    start_job(8'd4, 5'd2, 1'b0);
    feed(4, 8'd7, -8'sd3, 8'd10, 8'd10, 1'b1);
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL stress_extra_beat rdy=%b want 0", in_ready); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    while (!out_valid && g < 20) begin tick(); g++; end
    d = out_data; c = out_ch[0];
    tests++;
    if (d !== 8'hEB || c !== 1'b0) begin
      fails++; $display("FAIL stress_first got %h ch=%b want eb 0", d, c);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== d || out_ch[0] !== c || out_last !== 1'b0) begin
        fails++; $display("FAIL stress_hold cyc %0d vld=%b data=%h ch=%b want 1 %h %b",
                          k, out_valid, out_data, out_ch, d, c);
      end
    end
    collect();
    tests++;
    if (rd[0] !== 8'hEB || rd[1] !== 8'd100 || rl[1] !== 1'b1) begin
      fails++; $display("FAIL stress_result got %h %0d last=%b want eb 100 1", rd[0], rd[1], rl[1]);
    end
  endtask

  task automatic test_corners();
    start_job(8'd0, 5'd0, 1'b0);
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL len0_state rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    collect();
    tests++;
    if (rd[0] !== 8'd0 || rd[1] !== 8'd0 || rl[1] !== 1'b1) begin
      fails++; $display("FAIL len0_out got %0d %0d last=%b want 0 0 1", rd[0], rd[1], rl[1]);
    end

    start_job(8'd3, 5'd0, 1'b0);
    feed(1, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    start = 1'b1; cfg_len = 8'd1; cfg_shift = 5'd4; relu_en = 1'b1;
    tick();
    start = 1'b0;
    feed(2, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    collect();
    tests++;
    if (rd[0] !== 8'd18 || rd[1] !== 8'hC4) begin
      fails++; $display("FAIL start_in_accum got %h %h want 12 c4", rd[0], rd[1]);
    end

    start_job(8'd3, 5'd0, 1'b0);
    feed(1, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, out_data, out_ch, out_last, busy} !== 13'd0) begin
      fails++; $display("FAIL mid_reset rdy=%b vld=%b data=%h ch=%b last=%b busy=%b want all 0",
                        in_ready, out_valid, out_data, out_ch, out_last, busy);
    end
    start_job(8'd3, 5'd0, 1'b0);
    feed(3, 8'd2, 8'd3, -8'sd4, 8'd5, 1'b0);
    collect();
    tests++;
    if (rd[0] !== 8'd18 || rd[1] !== 8'hC4) begin
      fails++; $display("FAIL after_reset got %h %h want 12 c4", rd[0], rd[1]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_len = '0; cfg_shift = '0; in_a = '0; in_b = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_relu();
    test_saturation();
    test_back_to_back();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_nch_engine.md
Name: mac_nch_engine

Overview:
- Parametrised successor to the two-lane MAC datapath.
- N_CH parallel signed multiply-accumulate lanes consume operand beats over a valid/ready handshake for a programmable number of terms.
- Each lane's accumulator is then scaled by an arithmetic right shift, optionally passed through ReLU, saturated, and emitted one channel at a time on a valid/ready output stream.
- Sits between the operand loaders and the activation/serial output stage of the accelerator.

Parameters:
- N_CH, 2, number of parallel MAC lanes (>=1).
- DW, 8, operand width, signed two's-complement.
- ACC_W, 20, accumulator width, signed; must be >= 2*DW.
- OUT_W, 8, output word width, signed.
- LEN_W, 8, width of the term-count configuration.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- cfg_len  in  LEN_W  number of beats to accumulate; latched on start.
- cfg_shift  in  $clog2(ACC_W)  arithmetic right-shift amount; latched on start.
- relu_en  in  1  clamp negatives to 0; latched on start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat.
- in_a  in  N_CH*DW  lane operand A; lane i occupies bits [i*DW +: DW].
- in_b  in  N_CH*DW  lane operand B; same packing as in_a.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  scaled, activated, saturated lane result.
- out_ch  out  $clog2(N_CH) (min 1)  lane index of out_data.
- out_last  out  1  high with the final lane (N_CH-1).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE; all accumulators, product registers, counters and latched config clear to 0. Outputs reset to in_ready=0, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0. Reset overrides everything, including mid-job; no partial result is emitted.
- States: IDLE, ACCUM, DRAIN, SERIAL.
- IDLE:
  - On start, latch cfg_len, cfg_shift and relu_en; clear accumulators and the beat counter.
  - If cfg_len != 0, go to ACCUM; if cfg_len == 0, go to SERIAL, emitting zeros.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Pipeline stage 1: each lane registers the full-width signed product a*b (2*DW bits) plus a product-valid flag.
  - Pipeline stage 2: when product-valid is set, acc <= sat_ACC(acc + sext(product)).
  - in_valid gaps stall the count; no beat is lost or duplicated.
  - When the accepted-beat count reaches cfg_len, go to DRAIN; in_ready drops the next cycle.
- DRAIN: one cycle. The final product is added and in_ready=0. Then go to SERIAL.
- Latency: out_valid rises 2 cycles after the edge that accepted the last beat.
- Accumulator saturation: the sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and stays clamped on further beats of the same sign; opposite-sign beats move it off the rail normally.
- Result function, per lane, combinational in SERIAL:
  - r = acc >>> cfg_shift.
  - If relu_en and r < 0, r = 0.
  - out_data = r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- SERIAL:
  - out_valid=1, out_ch starts at 0; out_last = (out_ch == N_CH-1).
  - On out_valid && out_ready, out_ch increments. After the last handshake, go to IDLE with busy=0.
  - While out_ready=0, out_data, out_ch and out_last hold stable.
- start outside IDLE is ignored. start in the same cycle the last output handshake completes is also ignored; the next job needs start in IDLE.
- in_valid outside ACCUM is ignored.

Decomposition:
- Shared package mac_pkg:
  - state enum (IDLE/ACCUM/DRAIN/SERIAL).
  - localparams for ACC max/min and OUT max/min.
  - a saturating-resize function used both for the accumulator clamp and for the output clamp.
- One sub-module, mac_lane: product register, product-valid flag, saturating accumulator and clear input. Instantiate it N_CH times with a generate loop.
- Top level holds the FSM, counters, shift/ReLU/output saturation mux and the handshakes.

Test Plan (N_CH=2, DW=8, ACC_W=20, OUT_W=8):
- Basic: cfg_len=3, shift=0, relu_en=0; ch0 a=2,b=3 and ch1 a=-4,b=5 each beat -> out (ch0, 18), then (ch1, -60 = 0xC4) with out_last=1; out_valid rises exactly 2 cycles after the 3rd accepted beat.
- ReLU: same job with relu_en=1 -> ch0 18, ch1 0.
- Saturation: cfg_len=255, a=b=-128 on both lanes -> acc pinned at 524287. shift=12 -> out 127; shift=0 -> out 127 (output clamp).
- Handshake stress: random in_valid gaps plus out_ready held low 5 cycles in SERIAL -> results equal the gap-free run; out_data/out_ch stable while stalled; no extra beats accepted beyond cfg_len.
- Control corners: cfg_len=0 -> two outputs of 0 with no in_ready; start pulsed during ACCUM -> ignored; rst asserted mid-ACCUM -> next cycle IDLE, all outputs 0, and a fresh job gives correct results.
